// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity, then one or two stop bits; one-cycle done pulse.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] d_in,
    input  logic                 send,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  bit_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // tx_d is the line value for the next bit period, so tx stays a plain flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        bit_end = (baud_q == BAUD_LAST);

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                if (send) begin
                    shreg_d = d_in;
                    par_d   = (PARITY == 1) ? ~^d_in : ^d_in;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations (8N1, 7E2, 7O2) with a
// per-instance line monitor scoring observed frames against a queue.
module tb_uart_tx_param;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] send_v;
    logic [7:0] d_a;
    logic [6:0] d_b, d_c;
    logic [2:0] tx_v, busy_v, done_v;

    int checks = 0;
    int errors = 0;
    int dcnt[3];
    int exp_done[3];
    logic [11:0] q0[$];
    logic [11:0] q1[$];
    logic [11:0] q2[$];

    always #5 clk = ~clk;

    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .reset(reset), .d_in(d_a), .send(send_v[0]),
        .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .reset(reset), .d_in(d_b), .send(send_v[1]),
        .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
        .clk(clk), .reset(reset), .d_in(d_c), .send(send_v[2]),
        .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected line bits, LSB = start bit; unused upper bits read as idle-high.
    function automatic logic [11:0] mk(input int g, input logic [8:0] data);
        int unsigned d = (g == 0) ? 8 : 7;
        logic [11:0] f = '1;
        f[0] = 1'b0;
        for (int unsigned i = 0; i < d; i++) f[1+i] = data[i];
        if (g == 1) f[1+d] = ^data[6:0];
        if (g == 2) f[1+d] = ~^data[6:0];
        return f;
    endfunction

    task automatic sb_push(input int g, input logic [8:0] data);
        case (g)
            0: q0.push_back(mk(0, data));
            1: q1.push_back(mk(1, data));
            default: q2.push_back(mk(2, data));
        endcase
        exp_done[g]++;
    endtask

    task automatic sb_pop(input int g, output logic [11:0] v, output bit ok);
        ok = 1'b1;
        v  = '0;
        case (g)
            0: if (q0.size() == 0) ok = 1'b0; else v = q0.pop_front();
            1: if (q1.size() == 0) ok = 1'b0; else v = q1.pop_front();
            default: if (q2.size() == 0) ok = 1'b0; else v = q2.pop_front();
        endcase
    endtask

    for (genvar g = 0; g < 3; g++) begin : mon
        localparam int NB = (g == 0) ? 10 : 11;
        localparam int F  = NB * C;
        logic [11:0] obs, exp_f;
        int j;
        bit act, dlow, ok;
        initial begin
            act  = 1'b0;
            dlow = 1'b0;
            j    = 0;
            obs  = '1;
        end
        always @(negedge clk) begin
            if (reset) begin
                act  = 1'b0;
                dlow = 1'b0;
            end else begin
                if (done_v[g]) dcnt[g]++;
                if (dlow) begin
                    check($sformatf("done_low%0d", g), done_v[g], 1'b0);
                    dlow = 1'b0;
                end
                if (act) begin
                    if (j % C == C / 2) obs[j/C] = tx_v[g];
                    if (j == F - 1) check($sformatf("busy_end%0d", g), busy_v[g], 1'b1);
                    if (j == F) begin
                        check($sformatf("done_pulse%0d", g), done_v[g], 1'b1);
                        check($sformatf("busy_off%0d", g), busy_v[g], 1'b0);
                        check($sformatf("tx_idle%0d", g), tx_v[g], 1'b1);
                        sb_pop(g, exp_f, ok);
                        if (!ok) check($sformatf("sb_empty%0d", g), 1, 0);
                        else check($sformatf("frame%0d", g), obs, exp_f);
                        act  = 1'b0;
                        dlow = 1'b1;
                    end
                    j++;
                end else if (tx_v[g] == 1'b0) begin
                    act = 1'b1;
                    j   = 1;
                    obs = '1;
                    check($sformatf("busy_start%0d", g), busy_v[g], 1'b1);
                end
            end
        end
    end

    task automatic send_word(input int g, input logic [8:0] data);
        @(negedge clk);
        case (g)
            0: d_a = data[7:0];
            1: d_b = data[6:0];
            default: d_c = data[6:0];
        endcase
        sb_push(g, data);
        send_v[g] = 1'b1;
        @(negedge clk);
        send_v[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int n = 0;
        while (busy_v[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_timeout%0d", g), busy_v[g], 1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset  = 1'b1;
        send_v = '1;
        d_a = 8'h00; d_b = 7'h00; d_c = 7'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_tx", tx_v, 3'b111);
            check("rst_busy", busy_v, 3'b000);
            check("rst_done", done_v, 3'b000);
        end

        // Release reset with send already high: accept on first edge.
        d_a = 8'hA5;
        sb_push(0, 9'h0A5);
        send_v = 3'b001;
        reset  = 1'b0;
        @(negedge clk);
        check("first_accept", busy_v[0], 1'b1);
        send_v = '0;
        wait_idle(0);

        send_word(1, 9'h055);
        wait_idle(1);
        send_word(2, 9'h055);
        wait_idle(2);
        send_word(1, 9'h00B);
        wait_idle(1);
        send_word(2, 9'h033);
        wait_idle(2);

        // Streaming with send held high.
        @(negedge clk);
        d_a = 8'h00;
        send_v[0] = 1'b1;
        sb_push(0, 9'h000);
        @(negedge clk);
        d_a = 8'hFF;
        sb_push(0, 9'h0FF);
        n = 0;
        while (!done_v[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stream_done_seen", done_v[0], 1'b1);
        @(negedge clk);
        check("stream_gap_tx", tx_v[0], 1'b0);
        check("stream_gap_busy", busy_v[0], 1'b1);
        send_v[0] = 1'b0;
        wait_idle(0);

        // Send while busy is ignored.
        send_word(0, 9'h0A5);
        repeat (9) @(negedge clk);
        d_a = 8'h3C;
        send_v[0] = 1'b1;
        @(negedge clk);
        send_v[0] = 1'b0;
        wait_idle(0);
        repeat (10) @(negedge clk);

        // Reset during data bit 3 abandons the frame.
        send_word(0, 9'h05A);
        repeat (17) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_tx", tx_v[0], 1'b1);
        check("mid_rst_busy", busy_v[0], 1'b0);
        check("mid_rst_done", done_v[0], 1'b0);
        void'(q0.pop_back());
        exp_done[0]--;
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_done", done_v[0], 1'b0);
        end
        reset = 1'b0;
        send_word(0, 9'h0C3);
        wait_idle(0);

        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);
        check("q2_empty", q2.size(), 0);
        for (int g = 0; g < 3; g++) check($sformatf("done_count%0d", g), dcnt[g], exp_done[g]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
